// File: rtl/debug_view_pkg.sv
// Shared constants for the debug value viewer: digit count, SEL width and
// the active-low {g..a} hex font used by the 7-segment scanner.
package debug_view_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEL_W      = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the segment pattern for hex digit n (index 0 is rightmost).
  localparam logic [15:0][6:0] HEX_FONT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    return HEX_FONT[nib];
  endfunction

endpackage

// File: rtl/debug_view_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [1:0]       vld_q;
  logic             armed_q, armed_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  // A button held through reset must not step: rises are only honoured once
  // the synchronized input has been observed released after reset.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    armed_d = armed_q;
    if (vld_q[1] && !s2_q && !level_q) begin
      armed_d = 1'b1;
    end
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        rise_d  = s2_q & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/debug_view_ctrl.sv
// Debug viewer top: steps the selector code from a push button and scans the
// returned 32-bit value onto an 8-digit multiplexed 7-segment display.
// Optional leading-zero blanking: define DEBUG_VIEW_LZ_BLANK_EN.
module debug_view_ctrl
  import debug_view_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned NUM_SEL         = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_NEXT,
  input  logic [31:0]      Vdata,
  output logic [SEL_W-1:0] SEL,
  output logic [6:0]       SEG,
  output logic [7:0]       AN,
  output logic             DP
);

  localparam int unsigned SCAN_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SEL - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic              btn_level;
  logic              btn_rise;

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              tick;
  logic [2:0]        idx_nxt;
  logic [4:0]        nib_lsb;
  logic [3:0]        nib;
  logic              blank;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .CLK  (CLK),
    .RST  (RST),
    .raw  (BTN_NEXT),
    .level(btn_level),
    .rise (btn_rise)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q  <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      sel_q  <= sel_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (btn_rise) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end
  end

  assign tick    = (scan_q == SCAN_LAST);
  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
  assign nib_lsb = {idx_nxt, 2'b00};
  assign nib     = Vdata[nib_lsb +: 4];

`ifdef DEBUG_VIEW_LZ_BLANK_EN
  // Digit idx is a leading zero when every nibble from idx upward is zero.
  logic [31:0] upper;
  assign upper = Vdata >> nib_lsb;
  assign blank = (idx_nxt != 3'd0) && (upper == 32'd0);
`else
  assign blank = 1'b0;
`endif

  // Display registers load with the upcoming digit so AN and SEG change together.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    an_d   = an_q;
    seg_d  = seg_q;
    if (tick) begin
      scan_d = '0;
      idx_d  = idx_nxt;
      an_d   = ~(8'b1 << idx_nxt);
      seg_d  = blank ? SEG_BLANK : hex_font(nib);
    end
  end

  assign SEL = sel_q;
  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = 1'b1;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Directed bench for debug_view_ctrl with small debounce/scan parameters.
module tb_debug_view_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned SD  = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BTN_NEXT = 1'b0;
  logic [31:0] Vdata = 32'd0;
  logic [2:0]  SEL;
  logic [6:0]  SEG;
  logic [7:0]  AN;
  logic        DP;

  always #5 CLK = ~CLK;

  debug_view_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_DIV       (SD),
    .NUM_SEL        (6)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_NEXT(BTN_NEXT),
    .Vdata   (Vdata),
    .SEL     (SEL),
    .SEG     (SEG),
    .AN      (AN),
    .DP      (DP)
  );

  typedef struct {
    logic [31:0] vd;
    logic [7:0]  an;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic add(input logic [31:0] vd, input logic [7:0] an, input logic [6:0] seg);
    vec_t v;
    v.vd = vd; v.an = an; v.seg = seg;
    vecs.push_back(v);
  endtask

  // One vector per scan tick; ticks fall every SD cycles after reset release.
  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      Vdata = vecs[i].vd;
      cyc(SD);
      chk($sformatf("%s_an[%0d]", tag, i), {24'd0, AN}, {24'd0, vecs[i].an});
      chk($sformatf("%s_seg[%0d]", tag, i), {25'd0, SEG}, {25'd0, vecs[i].seg});
    end
  endtask

  task automatic press(input logic [2:0] exp);
    BTN_NEXT = 1'b1;
    cyc(20);
    BTN_NEXT = 1'b0;
    cyc(12);
    chk("press_sel", {29'd0, SEL}, {29'd0, exp});
  endtask

  initial begin
    int first;
    int n;

    @(negedge CLK);
    RST = 1'b1;
    Vdata = 32'h89ABCDEF;
    cyc(3);
    chk("rst_sel", {29'd0, SEL}, 32'd0);
    chk("rst_an", {24'd0, AN}, 32'hFF);
    chk("rst_seg", {25'd0, SEG}, 32'h7F);
    chk("rst_dp", {31'd0, DP}, 32'd1);
    RST = 1'b0;

    vecs.delete();
    add(32'h89ABCDEF, 8'b11111101, 7'b0000110);
    add(32'h89ABCDEF, 8'b11111011, 7'b0100001);
    add(32'h89ABCDEF, 8'b11110111, 7'b1000110);
    add(32'h89ABCDEF, 8'b11101111, 7'b0000011);
    add(32'h89ABCDEF, 8'b11011111, 7'b0001000);
    add(32'h89ABCDEF, 8'b10111111, 7'b0010000);
    add(32'h89ABCDEF, 8'b01111111, 7'b0000000);
    add(32'h89ABCDEF, 8'b11111110, 7'b0001110);
    add(32'h76543210, 8'b11111101, 7'b1111001);
    add(32'h76543210, 8'b11111011, 7'b0100100);
    add(32'h76543210, 8'b11110111, 7'b0110000);
    add(32'h76543210, 8'b11101111, 7'b0011001);
    add(32'h76543210, 8'b11011111, 7'b0010010);
    add(32'h76543210, 8'b10111111, 7'b0000010);
    add(32'h76543210, 8'b01111111, 7'b1111000);
    add(32'h76543210, 8'b11111110, 7'b1000000);
    run_table("scan");
    chk("dp_off", {31'd0, DP}, 32'd1);

    // Clean press: SEL must change on the 7th rising edge after the press.
    BTN_NEXT = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (first == 0 && SEL !== 3'd0) first = i;
    end
    chk("press_latency", first, 7);
    chk("press_step", {29'd0, SEL}, 32'd1);
    BTN_NEXT = 1'b0;
    cyc(20);
    chk("release_no_step", {29'd0, SEL}, 32'd1);

    // Bounce: 2-cycle toggles never survive the stability counter.
    for (int i = 0; i < 12; i++) begin
      BTN_NEXT = ((i % 4) < 2);
      cyc(1);
    end
    BTN_NEXT = 1'b1;
    cyc(20);
    BTN_NEXT = 1'b0;
    cyc(12);
    chk("bounce_one_step", {29'd0, SEL}, 32'd2);

    press(3'd3); press(3'd4); press(3'd5); press(3'd0);
    press(3'd1); press(3'd2); press(3'd3); press(3'd4); press(3'd5); press(3'd0);

    // Button held through reset produces no step until released and pressed.
    BTN_NEXT = 1'b1;
    RST = 1'b1;
    cyc(3);
    RST = 1'b0;
    cyc(20);
    chk("held_thru_reset", {29'd0, SEL}, 32'd0);
    BTN_NEXT = 1'b0;
    cyc(12);
    press(3'd1); press(3'd2); press(3'd3);

    // Reset in the middle of a scan, with digit 5 displayed and SEL=3.
    n = 0;
    while (n < 40 && AN !== 8'b11011111) begin
      cyc(1);
      n++;
    end
    chk("reach_digit5", {24'd0, AN}, 32'hDF);
    RST = 1'b1;
    cyc(1);
    chk("midrst_sel", {29'd0, SEL}, 32'd0);
    chk("midrst_an", {24'd0, AN}, 32'hFF);
    chk("midrst_seg", {25'd0, SEG}, 32'h7F);
    RST = 1'b0;
    cyc(SD);
    chk("midrst_first_tick", {24'd0, AN}, 32'hFD);

`ifdef DEBUG_VIEW_LZ_BLANK_EN
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    vecs.delete();
    add(32'h000000A5, 8'b11111101, 7'b0001000);
    add(32'h000000A5, 8'b11111011, 7'h7F);
    add(32'h000000A5, 8'b11110111, 7'h7F);
    add(32'h000000A5, 8'b11101111, 7'h7F);
    add(32'h000000A5, 8'b11011111, 7'h7F);
    add(32'h000000A5, 8'b10111111, 7'h7F);
    add(32'h000000A5, 8'b01111111, 7'h7F);
    add(32'h000000A5, 8'b11111110, 7'b0010010);
    add(32'h00000000, 8'b11111101, 7'h7F);
    add(32'h00000000, 8'b11111011, 7'h7F);
    add(32'h00000000, 8'b11110111, 7'h7F);
    add(32'h00000000, 8'b11101111, 7'h7F);
    add(32'h00000000, 8'b11011111, 7'h7F);
    add(32'h00000000, 8'b10111111, 7'h7F);
    add(32'h00000000, 8'b01111111, 7'h7F);
    add(32'h00000000, 8'b11111110, 7'b1000000);
    run_table("lz");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
